add_scheduler: RTL
==================

ADD_SCHEDULER -- requirements
Module: add_scheduler

Interface
- REQ-001 SHALL have parameter NBYTES, default 4: operand width in bytes, legal range 1..8; operand width W = 8*NBYTES.
- REQ-002 SHALL have port clk, input, 1: single clock; all state updates on rising edge.
- REQ-003 SHALL have port rst_n, input, 1: asynchronous active-low reset.
- REQ-004 SHALL have ports req0_valid / req1_valid, input, 1: requester N has an operation pending.
- REQ-005 SHALL have ports req0_ready / req1_ready, output, 1: requester N's operation is accepted this cycle.
- REQ-006 SHALL have ports req0_a, req0_b, req1_a, req1_b, input, W: operands.
- REQ-007 SHALL have ports req0_cin / req1_cin, input, 1: carry-in.
- REQ-008 SHALL have port rsp_valid, output, 1: result available.
- REQ-009 SHALL have port rsp_ready, input, 1: consumer accepts the result.
- REQ-010 SHALL have ports rsp_sum (output, W), rsp_cout (output, 1), rsp_id (output, 1): result, final carry, and index of the requester that issued the operation.

Function
- REQ-011 SHALL contain exactly one eight_bit_parallel_adder instance; all arithmetic SHALL go through it, one byte per cycle, LSB byte first.
- REQ-012 SHALL implement FSM states IDLE, ADD and DONE.
- REQ-013 IDLE: a req_ready SHALL be asserted combinationally only for the granted requester when its valid is high; both readies SHALL be low in ADD and DONE.
- REQ-014 Arbitration: if one valid is high, that requester is granted; if both are high, the requester not granted last is granted (round-robin).
- REQ-015 Accept edge (valid&&ready): latch a, b, id; set carry register to cin; set byte index to 0; go to ADD.
- REQ-016 ADD: each cycle SHALL add byte[idx] of a and b with the carry register, write sum byte[idx], update carry from adder cout, and increment idx; after byte NBYTES-1, go to DONE.
- REQ-017 Latency: rsp_valid SHALL rise exactly NBYTES cycles after the accept edge.
- REQ-018 DONE: rsp_valid=1; rsp_sum, rsp_cout and rsp_id SHALL stay stable until the rsp_valid&&rsp_ready edge, then go to IDLE.
- REQ-019 Back-to-back throughput: at most one accept per NBYTES+2 cycles; no accept SHALL occur in the handshake cycle itself.
- REQ-020 rsp_sum SHALL equal (a+b+cin) mod 2^W and rsp_cout SHALL equal bit W of a+b+cin, for all operand values including all-ones.
- REQ-021 Requester inputs that change after acceptance SHALL NOT affect the in-flight result.

Reset
- REQ-022 While rst_n=0: state=IDLE; rsp_valid=0, rsp_sum=0, rsp_cout=0, rsp_id=0, carry=0, idx=0; last-grant=1, so req0 wins the first tie.
- REQ-023 Reset asserted mid-ADD or mid-DONE SHALL discard the operation immediately; no rsp_valid SHALL be produced for it.

Configuration
- REQ-024 With macro ADD_SCHEDULER_OVF_EN defined: SHALL add output rsp_ovf (1) = signed overflow (a[W-1]==b[W-1] && rsp_sum[W-1]!=a[W-1]), held with rsp_sum and reset to 0.
- REQ-025 With ADD_SCHEDULER_OVF_EN undefined: rsp_ovf port and its logic SHALL be absent; all other behaviour is identical.

Verification (NBYTES=4)
- REQ-026 req0 a=0x000000FF, b=0x00000001, cin=0 -> rsp_valid 4 cycles after accept, rsp_sum=0x00000100, cout=0, id=0.
- REQ-027 req1 a=0xFFFFFFFF, b=0x00000000, cin=1 -> rsp_sum=0x00000000, cout=1, id=1 (full carry ripple across all bytes).
- REQ-028 req0 and req1 both held valid out of reset for 4 operations -> grant order 0,1,0,1; readies never high together.
- REQ-029 rsp_ready held low 10 cycles in DONE -> rsp outputs stable, both req_ready low; req_ready for the next request rises in the cycle after the handshake.
- REQ-030 rst_n pulsed low at the second ADD cycle -> rsp_valid stays 0, state IDLE; the next request completes correctly. With ADD_SCHEDULER_OVF_EN: a=0x7FFFFFFF, b=1 -> rsp_ovf=1.

Source files
------------

// File: rtl/add_scheduler.sv
`timescale 1ns/1ps
`default_nettype none
// +------------------------------------------------------------------------+
// | add_scheduler: two-requester round-robin front end that ripples a      |
// | W-bit add through one 8-bit adder, LSB byte first, one byte per cycle. |
// | Optional: ADD_SCHEDULER_OVF_EN adds the rsp_ovf signed-overflow flag.  |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+

module eight_bit_parallel_adder (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       cin,
  output logic [7:0] sum,
  output logic       cout
);
  assign {cout, sum} = 9'(a) + 9'(b) + 9'(cin);
endmodule

module add_scheduler #(
  parameter int NBYTES = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req0_valid,
  output logic                  req0_ready,
  input  logic [8*NBYTES-1:0]   req0_a,
  input  logic [8*NBYTES-1:0]   req0_b,
  input  logic                  req0_cin,
  input  logic                  req1_valid,
  output logic                  req1_ready,
  input  logic [8*NBYTES-1:0]   req1_a,
  input  logic [8*NBYTES-1:0]   req1_b,
  input  logic                  req1_cin,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [8*NBYTES-1:0]   rsp_sum,
  output logic                  rsp_cout,
  output logic                  rsp_id
`ifdef ADD_SCHEDULER_OVF_EN
  ,
  output logic                  rsp_ovf
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [2:0] c_last_idx = 3'(NBYTES - 1);

  state_t                  r_state;
  state_t                  w_state_nx;
  logic [NBYTES-1:0][7:0]  r_a;
  logic [NBYTES-1:0][7:0]  r_b;
  logic [NBYTES-1:0][7:0]  r_sum;
  logic                    r_carry;
  logic [2:0]              r_idx;
  logic                    r_last_grant;

  logic                    w_grant0;
  logic                    w_grant1;
  logic                    w_accept;
  logic                    w_last_byte;
  logic [7:0]              w_a_byte;
  logic [7:0]              w_b_byte;
  logic [7:0]              w_sum_byte;
  logic                    w_cout;

  // Tie goes to whoever did not win last; reset value 1 lets req0 win first.
  assign w_grant0    = req0_valid && (!req1_valid || r_last_grant);
  assign w_grant1    = req1_valid && !w_grant0;
  assign w_last_byte = (r_idx == c_last_idx);
  assign rsp_sum     = r_sum;

  always_comb begin
    w_a_byte = '0;
    w_b_byte = '0;
    for (int i = 0; i < NBYTES; i++) begin
      if (r_idx == 3'(i)) begin
        w_a_byte = r_a[i];
        w_b_byte = r_b[i];
      end
    end
  end

  eight_bit_parallel_adder u_adder (
    .a    (w_a_byte),
    .b    (w_b_byte),
    .cin  (r_carry),
    .sum  (w_sum_byte),
    .cout (w_cout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nx;
    end
  end

  always_comb begin
    w_state_nx = r_state;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    w_accept   = 1'b0;
    case (r_state)
      IDLE: begin
        req0_ready = w_grant0;
        req1_ready = w_grant1;
        w_accept   = w_grant0 || w_grant1;
        if (w_accept) w_state_nx = ADD;
      end
      ADD: begin
        if (w_last_byte) w_state_nx = DONE;
      end
      DONE: begin
        if (rsp_ready) w_state_nx = IDLE;
      end
      default: w_state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a          <= '0;
      r_b          <= '0;
      r_sum        <= '0;
      r_carry      <= 1'b0;
      r_idx        <= 3'd0;
      r_last_grant <= 1'b1;
      rsp_valid    <= 1'b0;
      rsp_cout     <= 1'b0;
      rsp_id       <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_a          <= w_grant1 ? req1_a : req0_a;
            r_b          <= w_grant1 ? req1_b : req0_b;
            r_carry      <= w_grant1 ? req1_cin : req0_cin;
            r_idx        <= 3'd0;
            rsp_id       <= w_grant1;
            r_last_grant <= w_grant1;
          end
        end
        ADD: begin
          for (int i = 0; i < NBYTES; i++) begin
            if (r_idx == 3'(i)) r_sum[i] <= w_sum_byte;
          end
          r_carry <= w_cout;
          r_idx   <= r_idx + 3'd1;
          if (w_last_byte) begin
            rsp_cout  <= w_cout;
            rsp_valid <= 1'b1;
          end
        end
        DONE: begin
          if (rsp_ready) rsp_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

`ifdef ADD_SCHEDULER_OVF_EN
  // Evaluated on the MSB byte so it lands together with the final sum.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_ovf <= 1'b0;
    end else if (r_state == ADD && w_last_byte) begin
      rsp_ovf <= (r_a[NBYTES-1][7] == r_b[NBYTES-1][7]) &&
                 (w_sum_byte[7] != r_a[NBYTES-1][7]);
    end
  end
`endif

endmodule

`default_nettype wire
